// File: rtl/ternary_mvm_core_if.sv
// ternary_mvm_core_if
//   Bundles the command/data word and the result/status outputs of
//   ternary_mvm_core so that a host and the core connect through one port.
//
//   Signals:
//     ui_input [15:0] host -> core  command / weight / activation word
//     uo_data  [7:0]  core -> host  saturated signed result
//     uo_valid        core -> host  uo_data holds a result this cycle
//     uo_busy         core -> host  core is not idle
//     uo_state [1:0]  core -> host  FSM state (0 IDLE, 1 LOAD, 2 MULT, 3 OUT)
//
//   Handshake: there is no ready/back-pressure. ui_input is sampled on every
//   rising clock edge and its meaning depends on uo_state; a result is
//   transferred in every cycle where uo_valid is high, and the host must
//   accept it in that cycle.
interface ternary_mvm_core_if;
    logic [15:0] ui_input;
    logic [7:0]  uo_data;
    logic        uo_valid;
    logic        uo_busy;
    logic [1:0]  uo_state;

    modport master (
        output ui_input,
        input  uo_data, uo_valid, uo_busy, uo_state
    );

    modport slave (
        input  ui_input,
        output uo_data, uo_valid, uo_busy, uo_state
    );
endinterface

// File: rtl/ternary_mvm_core.sv
// ternary_mvm_core
//   Ternary matrix-vector engine. A 0xA command loads 2-bit weights
//   (01 = +1, 11 = -1, else 0) row-major into an on-chip array, 8 weights
//   per 16-bit word. A 0xB command streams in_len signed activations, one per
//   cycle, accumulating one dot product per row, then emits out_len results
//   saturated to 8 bits, one per cycle. Weights persist across runs.
//
//   Ports:
//     clk     single clock, rising edge
//     rst     synchronous active-high reset
//     io_bus  slave side of ternary_mvm_core_if (input word, results, status)
module ternary_mvm_core #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int ACT_W       = 8,
    parameter int IN_W        = $clog2(MAX_IN_LEN),
    parameter int OUT_W       = $clog2(MAX_OUT_LEN),
    parameter int ACC_W       = ACT_W + IN_W
) (
    input  logic               clk,
    input  logic               rst,
    ternary_mvm_core_if.slave  io_bus
);

    // Column counter is wider than IN_W so that "column base + 8" used during
    // LOAD never wraps, even for small MAX_IN_LEN.
    localparam int CW = IN_W + 4;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MULT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [IN_W-1:0]          r_cfg_in_m1;
    logic [OUT_W-1:0]         r_cfg_out_m1;
    logic [OUT_W-1:0]         r_row;
    logic [CW-1:0]            r_col;
    logic [1:0]               r_w   [MAX_OUT_LEN][MAX_IN_LEN];
    logic signed [ACC_W-1:0]  r_acc [MAX_OUT_LEN];
    logic signed [ACC_W-1:0]  w_acc_nxt [MAX_OUT_LEN];
    logic [7:0]               r_data;
    logic                     r_valid;

    logic [3:0]               w_cmd;
    logic                     w_last_word;
    logic                     w_last_row;
    logic                     w_last_col;
    logic signed [ACC_W-1:0]  w_x;

    assign w_cmd       = io_bus.ui_input[15:12];
    // Current load word covers columns r_col..r_col+7; it is the row's last
    // word once that range reaches in_len-1.
    assign w_last_word = (r_col + CW'(8)) > CW'(r_cfg_in_m1);
    assign w_last_row  = (r_row == r_cfg_out_m1);
    assign w_last_col  = (r_col == CW'(r_cfg_in_m1));
    assign w_x         = {{IN_W{io_bus.ui_input[ACT_W-1]}}, io_bus.ui_input[ACT_W-1:0]};

    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX)      sat8 = 8'h7F;
        else if (a < SAT_MIN) sat8 = 8'h80;
        else                  sat8 = a[7:0];
    endfunction

    // Next value of every accumulator for the current activation column.
    always_comb begin
        for (int r = 0; r < MAX_OUT_LEN; r++) begin
            w_acc_nxt[r] = r_acc[r];
            if (OUT_W'(r) <= r_cfg_out_m1) begin
                case (r_w[r][r_col[IN_W-1:0]])
                    2'b01:   w_acc_nxt[r] = r_acc[r] + w_x;
                    2'b11:   w_acc_nxt[r] = r_acc[r] - w_x;
                    default: w_acc_nxt[r] = r_acc[r];
                endcase
            end
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd == 4'hA)      w_state_nxt = LOAD;
                else if (w_cmd == 4'hB) w_state_nxt = MULT;
            end
            LOAD: if (w_last_word && w_last_row) w_state_nxt = IDLE;
            MULT: if (w_last_col)                w_state_nxt = OUT;
            OUT:  if (w_last_row)                w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Datapath: config, counters, weight array, accumulators, output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_in_m1  <= '1;
            r_cfg_out_m1 <= '1;
            r_row        <= '0;
            r_col        <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            for (int r = 0; r < MAX_OUT_LEN; r++) begin
                r_acc[r] <= '0;
                for (int c = 0; c < MAX_IN_LEN; c++) r_w[r][c] <= 2'b00;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_row <= '0;
                    r_col <= '0;
                    if (w_cmd == 4'hA) begin
                        r_cfg_in_m1  <= io_bus.ui_input[11 -: IN_W];
                        r_cfg_out_m1 <= io_bus.ui_input[11-IN_W -: OUT_W];
                    end else if (w_cmd == 4'hB) begin
                        for (int r = 0; r < MAX_OUT_LEN; r++) r_acc[r] <= '0;
                    end
                end
                LOAD: begin
                    // Columns past in_len-1 in a row's last word are dropped.
                    for (int i = 0; i < 8; i++) begin
                        if ((r_col + CW'(i)) <= CW'(r_cfg_in_m1))
                            r_w[r_row][IN_W'(r_col + CW'(i))] <= io_bus.ui_input[2*i +: 2];
                    end
                    if (w_last_word) begin
                        r_col <= '0;
                        r_row <= r_row + OUT_W'(1);
                    end else begin
                        r_col <= r_col + CW'(8);
                    end
                end
                MULT: begin
                    for (int r = 0; r < MAX_OUT_LEN; r++) r_acc[r] <= w_acc_nxt[r];
                    r_col <= r_col + CW'(1);
                    if (w_last_col) begin
                        // Row 0 is presented in the first OUT cycle, so it is
                        // taken from the freshly updated accumulator value.
                        r_data  <= sat8(w_acc_nxt[0]);
                        r_valid <= 1'b1;
                        r_row   <= '0;
                    end
                end
                OUT: begin
                    // r_row is the index of the result currently on uo_data.
                    if (w_last_row) begin
                        r_data  <= '0;
                        r_valid <= 1'b0;
                        r_row   <= '0;
                    end else begin
                        r_data <= sat8(r_acc[OUT_W'(r_row + OUT_W'(1))]);
                        r_row  <= r_row + OUT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.uo_data  = r_data;
    assign io_bus.uo_valid = r_valid;
    assign io_bus.uo_busy  = (r_state != IDLE);
    assign io_bus.uo_state = r_state;

endmodule
